// File: rtl/loa_pll_ctrl_if.sv
// Signal bundle between the loa_pll controller, its system-side requester and the PLL pins.
// master = environment (system control + PLL), slave = controller.
interface loa_pll_ctrl_if;
  logic       start;
  logic       pll_lock;
  logic       cfg_req;
  logic [9:0] cfg_odiv;
  logic [9:0] cfg_duty;
  logic       cfg_ack;
  logic       cfg_err;
  logic       pll_pwd;
  logic       pll_rst;
  logic       rstodiv;
  logic [9:0] dyn_odiv;
  logic [9:0] dyn_duty;
  logic       clkout_gate;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;

  modport master (
    output start, pll_lock, cfg_req, cfg_odiv, cfg_duty,
    input  cfg_ack, cfg_err, pll_pwd, pll_rst, rstodiv, dyn_odiv, dyn_duty,
           clkout_gate, ready, fail, retry_cnt
  );

  modport slave (
    input  start, pll_lock, cfg_req, cfg_odiv, cfg_duty,
    output cfg_ack, cfg_err, pll_pwd, pll_rst, rstodiv, dyn_odiv, dyn_duty,
           clkout_gate, ready, fail, retry_cnt
  );
endinterface

// File: rtl/loa_pll_ctrl.sv
// Bring-up sequencer and dynamic-reconfig controller for the loa_pll clock generator.
// Debounces a synchronised pll_lock, gates clkout0 until lock is stable, retries on loss or timeout.
module loa_pll_ctrl #(
  parameter int PWD_CYC      = 10,
  parameter int RST_CYC      = 10,
  parameter int LOCK_STABLE  = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int MAX_RETRY    = 3,
  parameter int ODIV_RST     = 100,
  parameter int DUTY_RST     = 100
) (
  input logic           clk,
  input logic           rst,
  loa_pll_ctrl_if.slave bus
);

  localparam int PH_MAX0 = (PWD_CYC > RST_CYC) ? PWD_CYC : RST_CYC;
  localparam int PH_MAX  = (PH_MAX0 > LOCK_STABLE) ? PH_MAX0 : LOCK_STABLE;
  localparam int PH_W    = $clog2(PH_MAX + 1);
  localparam int TO_W    = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [PH_W-1:0] PWD_LAST  = PH_W'(PWD_CYC - 1);
  localparam logic [PH_W-1:0] RST_LAST  = PH_W'(RST_CYC - 1);
  localparam logic [PH_W-1:0] STB_LAST  = PH_W'(LOCK_STABLE - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]      RETRY_MAX = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_PWD, S_RST, S_WAIT_LOCK, S_STABLE, S_RUN, S_RECFG, S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [1:0]      retry_q, retry_d;
  logic [9:0]      odiv_q, odiv_d, duty_q, duty_d;
  logic            ack_q, ack_d, err_q, err_d;
  logic            pwd_q, pwd_d, prst_q, prst_d, rstodiv_q, rstodiv_d;
  logic            gate_q, gate_d, ready_q, ready_d, fail_q, fail_d;
  logic            sync1_q, lock_s_q;
  logic            go_retry;

  // duty may reach twice the divider; widen before comparing
  function automatic logic cfg_legal(input logic [9:0] odiv, input logic [9:0] duty);
    logic [10:0] lim;
    lim = {odiv, 1'b0};
    return (odiv != 10'd0) && (duty != 10'd0) && ({1'b0, duty} <= lim);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= bus.pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    to_d     = to_q;
    retry_d  = retry_q;
    odiv_d   = odiv_q;
    duty_d   = duty_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    go_retry = 1'b0;

    unique case (state_q)
      S_IDLE, S_FAIL: begin
        if (bus.start) begin
          state_d = S_PWD;
          ph_d    = '0;
          retry_d = '0;
        end
      end
      S_PWD: begin
        if (ph_q == PWD_LAST) begin
          state_d = S_RST;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_RST, S_RECFG: begin
        if (ph_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          ph_d    = '0;
          to_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        // timeout outranks a lock edge arriving in the same cycle
        if (to_q == TO_LAST) begin
          go_retry = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
          if (lock_s_q) begin
            if (LOCK_STABLE <= 1) begin
              state_d = S_RUN;
              retry_d = '0;
            end else begin
              state_d = S_STABLE;
              ph_d    = PH_W'(1);
            end
          end
        end
      end
      S_STABLE: begin
        if (to_q == TO_LAST) begin
          go_retry = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
            ph_d    = '0;
          end else if (ph_q == STB_LAST) begin
            state_d = S_RUN;
            retry_d = '0;
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        // err_q blocks the cycle in which the requester is still releasing cfg_req
        if (!lock_s_q) begin
          go_retry = 1'b1;
        end else if (bus.cfg_req && !err_q) begin
          if (cfg_legal(bus.cfg_odiv, bus.cfg_duty)) begin
            ack_d   = 1'b1;
            odiv_d  = bus.cfg_odiv;
            duty_d  = bus.cfg_duty;
            state_d = S_RECFG;
            ph_d    = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_retry) begin
      ph_d = '0;
      if (retry_q == RETRY_MAX) begin
        state_d = S_FAIL;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = S_PWD;
      end
    end

    pwd_d     = (state_d == S_PWD) || (state_d == S_FAIL);
    prst_d    = (state_d == S_RST);
    rstodiv_d = (state_d == S_RST) || (state_d == S_RECFG);
    gate_d    = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ph_q      <= '0;
      to_q      <= '0;
      retry_q   <= '0;
      odiv_q    <= 10'(ODIV_RST);
      duty_q    <= 10'(DUTY_RST);
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      pwd_q     <= 1'b0;
      prst_q    <= 1'b0;
      rstodiv_q <= 1'b0;
      gate_q    <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      to_q      <= to_d;
      retry_q   <= retry_d;
      odiv_q    <= odiv_d;
      duty_q    <= duty_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      pwd_q     <= pwd_d;
      prst_q    <= prst_d;
      rstodiv_q <= rstodiv_d;
      gate_q    <= gate_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign bus.cfg_ack     = ack_q;
  assign bus.cfg_err     = err_q;
  assign bus.pll_pwd     = pwd_q;
  assign bus.pll_rst     = prst_q;
  assign bus.rstodiv     = rstodiv_q;
  assign bus.dyn_odiv    = odiv_q;
  assign bus.dyn_duty    = duty_q;
  assign bus.clkout_gate = gate_q;
  assign bus.ready       = ready_q;
  assign bus.fail        = fail_q;
  assign bus.retry_cnt   = retry_q;

endmodule

// File: tb/tb_loa_pll_ctrl.sv
// Testbench for loa_pll_ctrl: time-stamp based reference model checked every cycle,
// plus directed scenarios with hand-computed cycle counts.
module tb_loa_pll_ctrl;
  localparam int PWD_CYC      = 4;
  localparam int RST_CYC      = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 100;
  localparam int MAX_RETRY    = 2;
  localparam int ODIV_RST     = 100;
  localparam int DUTY_RST     = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  loa_pll_ctrl_if bus();

  loa_pll_ctrl #(
    .PWD_CYC(PWD_CYC), .RST_CYC(RST_CYC), .LOCK_STABLE(LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .MAX_RETRY(MAX_RETRY),
    .ODIV_RST(ODIV_RST), .DUTY_RST(DUTY_RST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phases timed by entry stamps, lock debounce as a run length of
  // the 2-cycle-delayed lock samples.
  typedef enum int {M_IDLE, M_PWD, M_RST, M_LOCKING, M_RUN, M_RECFG, M_FAIL} mmode_t;

  mmode_t m_mode  = M_IDLE;
  int     cyc     = 0;
  int     m_t0    = 0;
  int     hi_run  = 0;
  int     m_retry = 0;
  int     m_odiv  = ODIV_RST;
  int     m_duty  = DUTY_RST;
  bit     m_ack   = 1'b0;
  bit     m_err   = 1'b0;
  bit     lk1     = 1'b0;
  bit     lk2     = 1'b0;
  bit     m_ls, m_prev_err;
  int     m_el;

  function automatic void m_enter(input mmode_t m);
    m_mode = m;
    m_t0   = cyc;
    hi_run = 0;
  endfunction

  function automatic void m_do_retry();
    if (m_retry == MAX_RETRY) begin
      m_enter(M_FAIL);
    end else begin
      m_retry++;
      m_enter(M_PWD);
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_mode = M_IDLE; m_t0 = cyc; hi_run = 0; m_retry = 0;
        m_odiv = ODIV_RST; m_duty = DUTY_RST; m_ack = 1'b0; m_err = 1'b0;
        lk1 = 1'b0; lk2 = 1'b0;
      end else begin
        cyc++;
        m_ls = lk2;
        lk2  = lk1;
        lk1  = bus.pll_lock;
        m_prev_err = m_err;
        m_ack = 1'b0;
        m_err = 1'b0;
        m_el  = cyc - m_t0;
        case (m_mode)
          M_IDLE, M_FAIL: if (bus.start) begin m_retry = 0; m_enter(M_PWD); end
          M_PWD:          if (m_el == PWD_CYC) m_enter(M_RST);
          M_RST, M_RECFG: if (m_el == RST_CYC) m_enter(M_LOCKING);
          M_LOCKING: begin
            if (m_el == LOCK_TIMEOUT) begin
              m_do_retry();
            end else begin
              hi_run = m_ls ? hi_run + 1 : 0;
              if (hi_run == LOCK_STABLE) begin
                m_retry = 0;
                m_enter(M_RUN);
              end
            end
          end
          M_RUN: begin
            if (!m_ls) begin
              m_do_retry();
            end else if (bus.cfg_req && !m_prev_err) begin
              if (int'(bus.cfg_odiv) >= 1 && int'(bus.cfg_duty) >= 1 &&
                  int'(bus.cfg_duty) <= 2 * int'(bus.cfg_odiv)) begin
                m_ack  = 1'b1;
                m_odiv = int'(bus.cfg_odiv);
                m_duty = int'(bus.cfg_duty);
                m_enter(M_RECFG);
              end else begin
                m_err = 1'b1;
              end
            end
          end
          default: m_enter(M_IDLE);
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_pll_pwd",  32'(bus.pll_pwd),     32'(m_mode == M_PWD || m_mode == M_FAIL));
      chk("cmp_pll_rst",  32'(bus.pll_rst),     32'(m_mode == M_RST));
      chk("cmp_rstodiv",  32'(bus.rstodiv),     32'(m_mode == M_RST || m_mode == M_RECFG));
      chk("cmp_gate",     32'(bus.clkout_gate), 32'(m_mode != M_RUN));
      chk("cmp_ready",    32'(bus.ready),       32'(m_mode == M_RUN));
      chk("cmp_fail",     32'(bus.fail),        32'(m_mode == M_FAIL));
      chk("cmp_ack",      32'(bus.cfg_ack),     32'(m_ack));
      chk("cmp_err",      32'(bus.cfg_err),     32'(m_err));
      chk("cmp_retry",    32'(bus.retry_cnt),   32'(m_retry));
      chk("cmp_dyn_odiv", 32'(bus.dyn_odiv),    32'(m_odiv));
      chk("cmp_dyn_duty", 32'(bus.dyn_duty),    32'(m_duty));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    step(1);
    #2 rst = 1'b0;
    step(1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pwd"},   32'(bus.pll_pwd),     32'd0);
    chk({tag, "_prst"},  32'(bus.pll_rst),     32'd0);
    chk({tag, "_rodiv"}, 32'(bus.rstodiv),     32'd0);
    chk({tag, "_odiv"},  32'(bus.dyn_odiv),    32'd100);
    chk({tag, "_duty"},  32'(bus.dyn_duty),    32'd100);
    chk({tag, "_gate"},  32'(bus.clkout_gate), 32'd1);
    chk({tag, "_ready"}, 32'(bus.ready),       32'd0);
    chk({tag, "_fail"},  32'(bus.fail),        32'd0);
    chk({tag, "_ack"},   32'(bus.cfg_ack),     32'd0);
    chk({tag, "_err"},   32'(bus.cfg_err),     32'd0);
    chk({tag, "_retry"}, 32'(bus.retry_cnt),   32'd0);
  endtask

  initial begin
    int k, t_r1, t_r2;
    bus.start = 1'b0; bus.pll_lock = 1'b0; bus.cfg_req = 1'b0;
    bus.cfg_odiv = 10'd0; bus.cfg_duty = 10'd0;
    step(2);
    chk_reset_vals("rst0");
    #2 rst = 1'b0;
    step(1);

    // Bring-up
    pulse_start();
    chk("t1_pwd_on", 32'(bus.pll_pwd), 32'd1);
    k = 0;
    while (bus.pll_pwd === 1'b1 && k < 50) begin k++; step(1); end
    chk("t1_pwd_len", 32'(k), 32'd4);
    chk("t1_rst_on", 32'(bus.pll_rst), 32'd1);
    k = 0;
    while (bus.pll_rst === 1'b1 && k < 50) begin k++; step(1); end
    chk("t1_rst_len", 32'(k), 32'd4);
    step(20);
    bus.pll_lock = 1'b1;
    k = 0;
    while (bus.ready !== 1'b1 && k < 200) begin step(1); k++; end
    chk("t1_lock_to_ready", 32'(k), 32'd10);
    chk("t1_gate_open", 32'(bus.clkout_gate), 32'd0);

    // Illegal reconfig requests
    bus.cfg_req = 1'b1; bus.cfg_odiv = 10'd0; bus.cfg_duty = 10'd5;
    step(1);
    chk("t4_err_odiv0", 32'(bus.cfg_err), 32'd1);
    chk("t4_noack_odiv0", 32'(bus.cfg_ack), 32'd0);
    bus.cfg_req = 1'b0;
    step(1);
    chk("t4_err_clears", 32'(bus.cfg_err), 32'd0);
    bus.cfg_req = 1'b1; bus.cfg_odiv = 10'd10; bus.cfg_duty = 10'd21;
    step(1);
    chk("t4_err_duty21", 32'(bus.cfg_err), 32'd1);
    step(1);
    chk("t4_held_req_blocked", 32'(bus.cfg_err), 32'd0);
    step(1);
    chk("t4_held_req_reeval", 32'(bus.cfg_err), 32'd1);
    bus.cfg_duty = 10'd0;
    step(1);
    bus.cfg_req = 1'b1;
    step(1);
    chk("t4_err_duty0", 32'(bus.cfg_err), 32'd1);
    bus.cfg_req = 1'b0;
    step(1);
    chk("t4_ready_kept", 32'(bus.ready), 32'd1);
    chk("t4_odiv_kept", 32'(bus.dyn_odiv), 32'd100);
    chk("t4_duty_kept", 32'(bus.dyn_duty), 32'd100);

    // Legal reconfig at the duty boundary handled elsewhere; here odiv=200 duty=200
    bus.cfg_req = 1'b1; bus.cfg_odiv = 10'd200; bus.cfg_duty = 10'd200;
    step(1);
    bus.cfg_req = 1'b0;
    chk("t3_ack", 32'(bus.cfg_ack), 32'd1);
    chk("t3_odiv", 32'(bus.dyn_odiv), 32'd200);
    chk("t3_duty", 32'(bus.dyn_duty), 32'd200);
    chk("t3_gate", 32'(bus.clkout_gate), 32'd1);
    chk("t3_ready_low", 32'(bus.ready), 32'd0);
    k = 0;
    while (bus.rstodiv === 1'b1 && k < 50) begin k++; step(1); end
    chk("t3_rstodiv_len", 32'(k), 32'd4);
    k = 0;
    while (bus.ready !== 1'b1 && k < 200) begin step(1); k++; end
    chk("t3_relock", 32'(k), 32'd8);

    // Lock glitch during bring-up
    bus.pll_lock = 1'b0;
    do_reset();
    chk_reset_vals("rst1");
    pulse_start();
    k = 0;
    while (bus.pll_rst !== 1'b1 && k < 50) begin step(1); k++; end
    while (bus.pll_rst === 1'b1 && k < 50) begin step(1); k++; end
    bus.pll_lock = 1'b1;
    step(5);
    bus.pll_lock = 1'b0;
    step(3);
    bus.pll_lock = 1'b1;
    chk("t2_no_early_run", 32'(bus.ready), 32'd0);
    k = 8;
    while (bus.ready !== 1'b1 && k < 200) begin step(1); k++; end
    chk("t2_glitch_to_ready", 32'(k), 32'd18);
    chk("t2_retry", 32'(bus.retry_cnt), 32'd0);

    // Timeouts into FAIL, then restart
    bus.pll_lock = 1'b0;
    do_reset();
    pulse_start();
    k = 1; t_r1 = 0; t_r2 = 0;
    while (bus.fail !== 1'b1 && k < 2000) begin
      step(1);
      k++;
      if (bus.retry_cnt == 2'd1 && t_r1 == 0) t_r1 = k;
      if (bus.retry_cnt == 2'd2 && t_r2 == 0) t_r2 = k;
    end
    chk("t5_retry1_at", 32'(t_r1), 32'd109);
    chk("t5_retry2_at", 32'(t_r2), 32'd217);
    chk("t5_fail_at", 32'(k), 32'd325);
    chk("t5_fail_pwd", 32'(bus.pll_pwd), 32'd1);
    chk("t5_fail_retry", 32'(bus.retry_cnt), 32'd2);
    chk("t5_fail_ready", 32'(bus.ready), 32'd0);
    step(3);
    pulse_start();
    chk("t5_restart_pwd", 32'(bus.pll_pwd), 32'd1);
    chk("t5_restart_fail", 32'(bus.fail), 32'd0);
    chk("t5_restart_retry", 32'(bus.retry_cnt), 32'd0);

    // Lock loss in RUN, then async reset mid-RST
    bus.pll_lock = 1'b1;
    k = 0;
    while (bus.ready !== 1'b1 && k < 400) begin step(1); k++; end
    chk("t6_run_reached", 32'(bus.ready), 32'd1);
    bus.pll_lock = 1'b0;
    k = 0;
    while (bus.ready === 1'b1 && k < 20) begin step(1); k++; end
    chk("t6_loss_latency", 32'(k), 32'd3);
    chk("t6_loss_pwd", 32'(bus.pll_pwd), 32'd1);
    chk("t6_loss_retry", 32'(bus.retry_cnt), 32'd1);
    k = 0;
    while (bus.pll_rst !== 1'b1 && k < 50) begin step(1); k++; end
    chk("t6_in_rst", 32'(bus.pll_rst), 32'd1);
    step(1);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("t6_async");
    step(1);
    #2 rst = 1'b0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
